// File: rtl/tcp_misc_pkg.sv
// tcp_misc_pkg: small stage-local types.
// rx_fsm_state_e sequences tcp_rx_proto_calc.
package tcp_misc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_STATE = 2'd1,
    CALC     = 2'd2,
    OUTPUT   = 2'd3
  } rx_fsm_state_e;

endpackage

// File: rtl/tcp_pkg.sv
// tcp_pkg: shared TCP engine types (header, flow state, payload, sched cmd).
// Widths here are the defaults used by the slow-path stages.
package tcp_pkg;

  localparam int TCP_FLOWID_W         = 8;
  localparam int TCP_RX_PAYLOAD_PTR_W = 14;
  localparam int TCP_TX_PAYLOAD_PTR_W = 14;

  typedef struct packed {
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic        ack_flag;
    logic [15:0] window;
  } tcp_pkt_hdr;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] size;
  } payload_buf_struct;

  typedef struct packed {
    logic [31:0] ack_num;
  } ack_state_struct;

  typedef struct packed {
    logic [31:0]     their_ack_num;
    logic [15:0]     our_win_size;
    ack_state_struct our_ack_state;
    logic [15:0]     their_win_size;
  } smol_rx_state_struct;

  typedef struct packed {
    logic [31:0] our_seq_num;
  } smol_tx_state_struct;

  typedef enum logic [1:0] {
    SCHED_NOP   = 2'd0,
    SCHED_SET   = 2'd1,
    SCHED_CLEAR = 2'd2
  } sched_flag_e;

  typedef struct packed {
    logic [TCP_FLOWID_W-1:0] flowid;
    sched_flag_e             ack_pend;
    sched_flag_e             rt_pend;
    sched_flag_e             data_pend;
    logic [31:0]             timestamp;
  } sched_cmd_struct;

endpackage

// File: rtl/tcp_ack_window_check.sv
// tcp_ack_window_check: modular ACK classification against unacked window.
// In: hdr_ack, ack_state, our_seq. Out: d_ack, new_ack, win_valid.
module tcp_ack_window_check (
  input  logic [31:0] hdr_ack,
  input  logic [31:0] ack_state,
  input  logic [31:0] our_seq,
  output logic [31:0] d_ack,
  output logic        new_ack,
  output logic        win_valid
);

  logic [31:0] d_out;

  // distances from the last ack wrap naturally mod 2^32
  assign d_ack     = hdr_ack - ack_state;
  assign d_out     = our_seq - ack_state;
  assign win_valid = (d_ack <= d_out);
  assign new_ack   = (d_ack != '0) && win_valid;

endmodule

// File: rtl/tcp_rx_proto_calc.sv
// tcp_rx_proto_calc: RX seq/ack check, state writeback, commit, sched update.
// Ports: rx_hdr val/rdy in, state rd/wr, tx head ptr wr, commit, sched out.
module tcp_rx_proto_calc
  import tcp_pkg::*;
  import tcp_misc_pkg::*;
#(
  parameter int FLOWID_W         = TCP_FLOWID_W,
  parameter int RX_PAYLOAD_PTR_W = TCP_RX_PAYLOAD_PTR_W,
  parameter int TX_PAYLOAD_PTR_W = TCP_TX_PAYLOAD_PTR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_hdr_val,
  output logic                      rx_hdr_rdy,
  input  tcp_pkt_hdr                rx_hdr,
  input  logic [FLOWID_W-1:0]       rx_flowid,
  input  payload_buf_struct         rx_payload,
  output logic [FLOWID_W-1:0]       rx_state_rd_req_addr,
  input  smol_rx_state_struct       rx_state_rd_resp_data,
  output logic [FLOWID_W-1:0]       tx_state_rd_req_addr,
  input  smol_tx_state_struct       tx_state_rd_resp_data,
  output logic                      rx_state_wr_req_val,
  output logic [FLOWID_W-1:0]       rx_state_wr_req_addr,
  output smol_rx_state_struct       rx_state_wr_req_data,
  output logic                      tx_head_ptr_wr_req_val,
  output logic [FLOWID_W-1:0]       tx_head_ptr_wr_req_addr,
  output logic [TX_PAYLOAD_PTR_W:0] tx_head_ptr_wr_req_data,
  output logic                      rx_commit_val,
  input  logic                      rx_commit_rdy,
  output logic                      rx_commit_accept,
  output payload_buf_struct         rx_commit_desc,
  output logic [FLOWID_W-1:0]       rx_commit_flowid,
  output logic                      rx_sched_update_val,
  input  logic                      rx_sched_update_rdy,
  output sched_cmd_struct           rx_sched_update_cmd
);

  rx_fsm_state_e       state;
  logic                rd_wait;
  tcp_pkt_hdr          hdr_q;
  logic [FLOWID_W-1:0] flowid_q;
  payload_buf_struct   payload_q;
  smol_rx_state_struct rx_st_q;
  smol_tx_state_struct tx_st_q;

  logic [31:0] d_ack;
  logic        ack_new;
  logic        win_valid;

  logic [31:0]         len32;
  logic                in_order;
  logic                fits;
  logic                has_data;
  logic                accept_c;
  logic                new_ack_c;
  logic                win_upd_c;
  smol_rx_state_struct st_c;
  payload_buf_struct   desc_c;
  sched_cmd_struct     cmd_c;
  logic                commit_done;
  logic                sched_done;

  assign rx_state_rd_req_addr    = flowid_q;
  assign tx_state_rd_req_addr    = flowid_q;
  assign rx_state_wr_req_addr    = flowid_q;
  assign tx_head_ptr_wr_req_addr = flowid_q;
  assign rx_commit_flowid        = flowid_q;

  tcp_ack_window_check u_ack (
    .hdr_ack   (hdr_q.ack_num),
    .ack_state (rx_st_q.our_ack_state.ack_num),
    .our_seq   (tx_st_q.our_seq_num),
    .d_ack     (d_ack),
    .new_ack   (ack_new),
    .win_valid (win_valid)
  );

  always_comb begin
    len32     = 32'(payload_q.size);
    in_order  = (hdr_q.seq_num == rx_st_q.their_ack_num);
    fits      = (payload_q.size <= rx_st_q.our_win_size);
    has_data  = (payload_q.size != '0);
    accept_c  = in_order & fits & has_data;
    new_ack_c = hdr_q.ack_flag & ack_new & (d_ack != '0);
    win_upd_c = hdr_q.ack_flag & win_valid;

    st_c        = rx_st_q;
    desc_c.size = payload_q.size;
    // a drop frees the staging slot, so it carries the staging address
    desc_c.addr = payload_q.addr;
    if (accept_c) begin
      st_c.their_ack_num = rx_st_q.their_ack_num + len32;
      st_c.our_win_size  = rx_st_q.our_win_size - payload_q.size;
      desc_c.addr =
        32'(rx_st_q.their_ack_num[RX_PAYLOAD_PTR_W-1:0]);
    end
    if (new_ack_c) begin
      st_c.our_ack_state.ack_num = hdr_q.ack_num;
    end
    if (win_upd_c) begin
      st_c.their_win_size = hdr_q.window;
    end

    cmd_c           = '0;
    cmd_c.flowid    = flowid_q;
    cmd_c.ack_pend  = SCHED_NOP;
    cmd_c.rt_pend   = SCHED_NOP;
    cmd_c.data_pend = SCHED_NOP;
    if (has_data) begin
      cmd_c.ack_pend = SCHED_SET;
    end
    if (new_ack_c) begin
      cmd_c.rt_pend   = SCHED_CLEAR;
      cmd_c.data_pend = SCHED_SET;
    end
  end

  assign commit_done = !rx_commit_val || rx_commit_rdy;
  assign sched_done  = !rx_sched_update_val || rx_sched_update_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                   <= IDLE;
      rd_wait                 <= 1'b0;
      rx_hdr_rdy              <= 1'b0;
      hdr_q                   <= '0;
      flowid_q                <= '0;
      payload_q               <= '0;
      rx_st_q                 <= '0;
      tx_st_q                 <= '0;
      rx_state_wr_req_val     <= 1'b0;
      rx_state_wr_req_data    <= '0;
      tx_head_ptr_wr_req_val  <= 1'b0;
      tx_head_ptr_wr_req_data <= '0;
      rx_commit_val           <= 1'b0;
      rx_commit_accept        <= 1'b0;
      rx_commit_desc          <= '0;
      rx_sched_update_val     <= 1'b0;
      rx_sched_update_cmd     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rx_hdr_val && rx_hdr_rdy) begin
            hdr_q      <= rx_hdr;
            flowid_q   <= rx_flowid;
            payload_q  <= rx_payload;
            rx_hdr_rdy <= 1'b0;
            rd_wait    <= 1'b0;
            state      <= RD_STATE;
          end else begin
            rx_hdr_rdy <= 1'b1;
          end
        end
        RD_STATE: begin
          // first cycle presents the address, second sees the data
          if (rd_wait) begin
            rx_st_q <= rx_state_rd_resp_data;
            tx_st_q <= tx_state_rd_resp_data;
            state   <= CALC;
          end else begin
            rd_wait <= 1'b1;
          end
        end
        CALC: begin
          rx_state_wr_req_val     <= 1'b1;
          rx_state_wr_req_data    <= st_c;
          tx_head_ptr_wr_req_val  <= new_ack_c;
          tx_head_ptr_wr_req_data <=
            hdr_q.ack_num[TX_PAYLOAD_PTR_W:0];
          rx_commit_val           <= has_data;
          rx_commit_accept        <= accept_c;
          rx_commit_desc          <= desc_c;
          rx_sched_update_val     <= has_data | new_ack_c;
          rx_sched_update_cmd     <= cmd_c;
          state                   <= OUTPUT;
        end
        OUTPUT: begin
          rx_state_wr_req_val    <= 1'b0;
          tx_head_ptr_wr_req_val <= 1'b0;
          if (rx_commit_rdy) begin
            rx_commit_val <= 1'b0;
          end
          if (rx_sched_update_rdy) begin
            rx_sched_update_val <= 1'b0;
          end
          if (commit_done && sched_done) begin
            rx_hdr_rdy <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_rx_proto_calc.sv
// tb_tcp_rx_proto_calc: random + directed segments vs a behavioural model.
// Flow state tables live in the bench with 1-cycle read latency.
module tb_tcp_rx_proto_calc;
  import tcp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                rx_hdr_val;
  logic                rx_hdr_rdy;
  tcp_pkt_hdr          rx_hdr;
  logic [7:0]          rx_flowid;
  payload_buf_struct   rx_payload;
  logic [7:0]          rx_state_rd_req_addr;
  smol_rx_state_struct rx_state_rd_resp_data;
  logic [7:0]          tx_state_rd_req_addr;
  smol_tx_state_struct tx_state_rd_resp_data;
  logic                rx_state_wr_req_val;
  logic [7:0]          rx_state_wr_req_addr;
  smol_rx_state_struct rx_state_wr_req_data;
  logic                tx_head_ptr_wr_req_val;
  logic [7:0]          tx_head_ptr_wr_req_addr;
  logic [14:0]         tx_head_ptr_wr_req_data;
  logic                rx_commit_val;
  logic                rx_commit_rdy;
  logic                rx_commit_accept;
  payload_buf_struct   rx_commit_desc;
  logic [7:0]          rx_commit_flowid;
  logic                rx_sched_update_val;
  logic                rx_sched_update_rdy;
  sched_cmd_struct     rx_sched_update_cmd;

  tcp_rx_proto_calc dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .rx_hdr_val              (rx_hdr_val),
    .rx_hdr_rdy              (rx_hdr_rdy),
    .rx_hdr                  (rx_hdr),
    .rx_flowid               (rx_flowid),
    .rx_payload              (rx_payload),
    .rx_state_rd_req_addr    (rx_state_rd_req_addr),
    .rx_state_rd_resp_data   (rx_state_rd_resp_data),
    .tx_state_rd_req_addr    (tx_state_rd_req_addr),
    .tx_state_rd_resp_data   (tx_state_rd_resp_data),
    .rx_state_wr_req_val     (rx_state_wr_req_val),
    .rx_state_wr_req_addr    (rx_state_wr_req_addr),
    .rx_state_wr_req_data    (rx_state_wr_req_data),
    .tx_head_ptr_wr_req_val  (tx_head_ptr_wr_req_val),
    .tx_head_ptr_wr_req_addr (tx_head_ptr_wr_req_addr),
    .tx_head_ptr_wr_req_data (tx_head_ptr_wr_req_data),
    .rx_commit_val           (rx_commit_val),
    .rx_commit_rdy           (rx_commit_rdy),
    .rx_commit_accept        (rx_commit_accept),
    .rx_commit_desc          (rx_commit_desc),
    .rx_commit_flowid        (rx_commit_flowid),
    .rx_sched_update_val     (rx_sched_update_val),
    .rx_sched_update_rdy     (rx_sched_update_rdy),
    .rx_sched_update_cmd     (rx_sched_update_cmd)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] a,
                     input logic [127:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic tmo(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // state tables, written only here
  smol_rx_state_struct rx_mem [256];
  smol_tx_state_struct tx_mem [256];
  logic                bset = 1'b0;
  logic [7:0]          bflow;
  smol_rx_state_struct brx;
  smol_tx_state_struct btx;

  always @(posedge clk) begin
    rx_state_rd_resp_data <= rx_mem[rx_state_rd_req_addr];
    tx_state_rd_resp_data <= tx_mem[tx_state_rd_req_addr];
    if (rx_state_wr_req_val)
      rx_mem[rx_state_wr_req_addr] <= rx_state_wr_req_data;
    if (bset) begin
      rx_mem[bflow] <= brx;
      tx_mem[bflow] <= btx;
    end
  end

  // ready drivers
  int   rdy_mode = 0;
  logic f_commit = 1'b1;
  logic f_sched = 1'b1;
  initial begin
    rx_commit_rdy = 1'b0;
    rx_sched_update_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rdy_mode == 0) begin
        rx_commit_rdy = ($urandom % 3) != 0;
        rx_sched_update_rdy = ($urandom % 3) != 0;
      end else begin
        rx_commit_rdy = f_commit;
        rx_sched_update_rdy = f_sched;
      end
    end
  end

  // model state and current expectation
  smol_rx_state_struct mdl_rx [16];
  smol_tx_state_struct mdl_tx [16];
  bit                  exp_valid = 1'b0;
  logic [7:0]          e_flow;
  smol_rx_state_struct e_wr;
  bit                  e_head_val;
  logic [14:0]         e_head;
  bit                  e_commit_val;
  bit                  e_accept;
  payload_buf_struct   e_desc;
  bit                  e_sched_val;
  sched_cmd_struct     e_cmd;
  int seen_wr, seen_head, commit_done, sched_done;
  logic                l_accept;
  payload_buf_struct   l_desc;
  sched_cmd_struct     l_cmd;
  logic [14:0]         l_head;

  always @(negedge clk) begin
    if (exp_valid) begin
      if (rx_state_wr_req_val) begin
        seen_wr++;
        chk("wr_addr", 128'(rx_state_wr_req_addr), 128'(e_flow));
        chk("wr_data", 128'(rx_state_wr_req_data), 128'(e_wr));
      end
      if (tx_head_ptr_wr_req_val) begin
        seen_head++;
        l_head = tx_head_ptr_wr_req_data;
        chk("head_addr", 128'(tx_head_ptr_wr_req_addr), 128'(e_flow));
        chk("head_data", 128'(tx_head_ptr_wr_req_data), 128'(e_head));
      end
      if (rx_commit_val && rx_commit_rdy) begin
        commit_done++;
        l_accept = rx_commit_accept;
        l_desc = rx_commit_desc;
        chk("commit_accept", 128'(rx_commit_accept), 128'(e_accept));
        chk("commit_desc", 128'(rx_commit_desc), 128'(e_desc));
        chk("commit_flow", 128'(rx_commit_flowid), 128'(e_flow));
      end
      if (rx_sched_update_val && rx_sched_update_rdy) begin
        sched_done++;
        l_cmd = rx_sched_update_cmd;
        chk("sched_cmd", 128'(rx_sched_update_cmd), 128'(e_cmd));
      end
    end else begin
      chk("idle_vals", 128'({rx_state_wr_req_val, tx_head_ptr_wr_req_val,
                             rx_commit_val, rx_sched_update_val}), 128'(0));
    end
  end

  task automatic set_flow(input logic [7:0] f, input smol_rx_state_struct r,
                          input smol_tx_state_struct t);
    bflow = f;
    brx = r;
    btx = t;
    bset = 1'b1;
    @(posedge clk);
    #1 bset = 1'b0;
    mdl_rx[f[3:0]] = r;
    mdl_tx[f[3:0]] = t;
  endtask

  function automatic smol_rx_state_struct mk_rx(
    input logic [31:0] ta, input logic [15:0] w,
    input logic [31:0] as, input logic [15:0] tw);
    smol_rx_state_struct r;
    r.their_ack_num = ta;
    r.our_win_size = w;
    r.our_ack_state.ack_num = as;
    r.their_win_size = tw;
    return r;
  endfunction

  function automatic smol_tx_state_struct mk_tx(input logic [31:0] s);
    smol_tx_state_struct t;
    t.our_seq_num = s;
    return t;
  endfunction

  function automatic tcp_pkt_hdr mk_hdr(input logic [31:0] sq,
    input logic [31:0] ak, input logic fl, input logic [15:0] w);
    tcp_pkt_hdr h;
    h.seq_num = sq;
    h.ack_num = ak;
    h.ack_flag = fl;
    h.window = w;
    return h;
  endfunction

  function automatic payload_buf_struct mk_pl(input logic [31:0] a,
                                              input logic [15:0] s);
    payload_buf_struct p;
    p.addr = a;
    p.size = s;
    return p;
  endfunction

  task automatic start_seg(input logic [7:0] f, input tcp_pkt_hdr h,
                           input payload_buf_struct p);
    smol_rx_state_struct s;
    logic [31:0] dack, dout;
    bit acc, nack;
    int n = 0;
    while (rx_hdr_rdy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (rx_hdr_rdy !== 1'b1) begin
      tmo("hdr_rdy_wait");
      return;
    end
    @(posedge clk);
    #1;
    rx_hdr_val = 1'b1;
    rx_hdr = h;
    rx_flowid = f;
    rx_payload = p;
    @(posedge clk);
    s = mdl_rx[f[3:0]];
    acc = (h.seq_num == s.their_ack_num) &&
          (p.size <= s.our_win_size) && (p.size != 0);
    e_desc.size = p.size;
    e_desc.addr = acc ? (s.their_ack_num & 32'h3FFF) : p.addr;
    if (acc) begin
      s.their_ack_num = s.their_ack_num + 32'(p.size);
      s.our_win_size = s.our_win_size - p.size;
    end
    nack = 0;
    if (h.ack_flag) begin
      dack = h.ack_num - mdl_rx[f[3:0]].our_ack_state.ack_num;
      dout = mdl_tx[f[3:0]].our_seq_num -
             mdl_rx[f[3:0]].our_ack_state.ack_num;
      if (dack <= dout) begin
        s.their_win_size = h.window;
        if (dack != 0) begin
          nack = 1;
          s.our_ack_state.ack_num = h.ack_num;
        end
      end
    end
    e_flow = f;
    e_wr = s;
    e_head_val = nack;
    e_head = h.ack_num[14:0];
    e_commit_val = (p.size != 0);
    e_accept = acc;
    e_cmd = '0;
    e_cmd.flowid = f;
    e_cmd.ack_pend = SCHED_NOP;
    e_cmd.rt_pend = SCHED_NOP;
    e_cmd.data_pend = SCHED_NOP;
    if (p.size != 0) e_cmd.ack_pend = SCHED_SET;
    if (nack) begin
      e_cmd.rt_pend = SCHED_CLEAR;
      e_cmd.data_pend = SCHED_SET;
    end
    e_sched_val = (p.size != 0) || nack;
    mdl_rx[f[3:0]] = s;
    seen_wr = 0;
    seen_head = 0;
    commit_done = 0;
    sched_done = 0;
    l_accept = 1'bx;
    l_desc = 'x;
    l_cmd = 'x;
    l_head = 'x;
    exp_valid = 1'b1;
    #1 rx_hdr_val = 1'b0;
  endtask

  task automatic finish_seg();
    int n = 0;
    @(negedge clk);
    while (rx_hdr_rdy !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (rx_hdr_rdy !== 1'b1) tmo("seg_done_wait");
    chk("n_state_wr", 128'(seen_wr), 128'(1));
    chk("n_head_wr", 128'(seen_head), 128'(e_head_val));
    chk("n_commit", 128'(commit_done), 128'(e_commit_val));
    chk("n_sched", 128'(sched_done), 128'(e_sched_val));
    exp_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1, "timeout");
  end

  initial begin
    tcp_pkt_hdr h;
    payload_buf_struct p;
    smol_rx_state_struct s;
    smol_tx_state_struct t;
    logic [7:0] f;
    int n;
    rx_hdr_val = 1'b0;
    rx_hdr = '0;
    rx_flowid = '0;
    rx_payload = '0;
    #1;
    chk("rst_hdr_rdy", 128'(rx_hdr_rdy), 128'(0));
    for (int i = 0; i < 16; i++) begin
      s = mk_rx($urandom, 16'($urandom_range(0, 8000)),
                $urandom, 16'($urandom));
      t = mk_tx(s.our_ack_state.ack_num + $urandom_range(0, 5000));
      set_flow(8'(i), s, t);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle_hdr_rdy", 128'(rx_hdr_rdy), 128'(1));

    // in-order data
    set_flow(3, mk_rx(1000, 4096, 5000, 100), mk_tx(5000));
    start_seg(3, mk_hdr(1000, 0, 0, 0), mk_pl(32'h2222, 200));
    finish_seg();
    chk("io_accept", 128'(l_accept), 128'(1));
    chk("io_addr", 128'(l_desc.addr), 128'(1000));
    chk("io_len", 128'(l_desc.size), 128'(200));
    chk("io_their_ack", 128'(rx_mem[3].their_ack_num), 128'(1200));
    chk("io_our_win", 128'(rx_mem[3].our_win_size), 128'(3896));
    chk("io_ack_pend", 128'(l_cmd.ack_pend), 128'(SCHED_SET));

    // out-of-order data
    set_flow(3, mk_rx(1000, 4096, 5000, 100), mk_tx(5000));
    start_seg(3, mk_hdr(1400, 0, 0, 0), mk_pl(32'h3333, 100));
    finish_seg();
    chk("ooo_accept", 128'(l_accept), 128'(0));
    chk("ooo_their_ack", 128'(rx_mem[3].their_ack_num), 128'(1000));
    chk("ooo_our_win", 128'(rx_mem[3].our_win_size), 128'(4096));
    chk("ooo_ack_pend", 128'(l_cmd.ack_pend), 128'(SCHED_SET));

    // new ack across the 32-bit wrap
    set_flow(5, mk_rx(32'h1234, 100, 32'hFFFF_FFF0, 7), mk_tx(32'h10));
    start_seg(5, mk_hdr(32'h1234, 32'h8, 1, 512), mk_pl(0, 0));
    finish_seg();
    chk("wrap_head", 128'(l_head), 128'(15'h0008));
    chk("wrap_rt_pend", 128'(l_cmd.rt_pend), 128'(SCHED_CLEAR));
    chk("wrap_their_win", 128'(rx_mem[5].their_win_size), 128'(512));
    chk("wrap_ack_state",
        128'(rx_mem[5].our_ack_state.ack_num), 128'(8));

    // ack beyond what was sent
    set_flow(6, mk_rx(0, 100, 500, 77), mk_tx(600));
    start_seg(6, mk_hdr(0, 700, 1, 999), mk_pl(0, 0));
    finish_seg();
    chk("stale_head_wr", 128'(seen_head), 128'(0));
    chk("stale_sched", 128'(sched_done), 128'(0));
    chk("stale_their_win", 128'(rx_mem[6].their_win_size), 128'(77));
    chk("stale_ack_state",
        128'(rx_mem[6].our_ack_state.ack_num), 128'(500));

    // scheduler backpressure
    rdy_mode = 1;
    f_commit = 1'b1;
    f_sched = 1'b0;
    set_flow(7, mk_rx(4000, 1000, 10, 5), mk_tx(20));
    start_seg(7, mk_hdr(4000, 0, 0, 0), mk_pl(32'h44, 50));
    n = 0;
    while (rx_sched_update_val !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (rx_sched_update_val !== 1'b1) tmo("bp_sched_val");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hdr_rdy_low", 128'(rx_hdr_rdy), 128'(0));
    end
    chk("bp_single_wr", 128'(seen_wr), 128'(1));
    @(posedge clk);
    f_sched = 1'b1;
    @(negedge clk);
    chk("bp_rdy_cycle", 128'(rx_hdr_rdy), 128'(0));
    @(negedge clk);
    chk("bp_idle_next", 128'(rx_hdr_rdy), 128'(1));
    finish_seg();
    chk("bp_commit_addr", 128'(l_desc.addr), 128'(4000));

    // reset while outputs are stalled
    f_commit = 1'b0;
    f_sched = 1'b0;
    set_flow(8, mk_rx(900, 500, 10, 5), mk_tx(20));
    start_seg(8, mk_hdr(900, 0, 0, 0), mk_pl(32'h55, 30));
    n = 0;
    while (seen_wr == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (seen_wr == 0) tmo("rst_wait_wr");
    @(posedge clk);
    #2;
    exp_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_vals", 128'({rx_state_wr_req_val, tx_head_ptr_wr_req_val,
                          rx_commit_val, rx_sched_update_val}), 128'(0));
    chk("rst_hdr_rdy2", 128'(rx_hdr_rdy), 128'(0));
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    rdy_mode = 0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_rdy", 128'(rx_hdr_rdy), 128'(1));
    start_seg(8, mk_hdr(930, 0, 0, 0), mk_pl(32'h66, 10));
    finish_seg();
    chk("post_rst_accept", 128'(l_accept), 128'(1));
    chk("post_rst_their_ack", 128'(rx_mem[8].their_ack_num), 128'(940));

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      f = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) begin
        s = mdl_rx[f[3:0]];
        s.our_win_size = 16'($urandom_range(0, 8000));
        t = mdl_tx[f[3:0]];
        t.our_seq_num = t.our_seq_num + $urandom_range(0, 3000);
        set_flow(f, s, t);
      end
      s = mdl_rx[f[3:0]];
      if ($urandom % 2 == 0) h.seq_num = s.their_ack_num;
      else if ($urandom % 2 == 0)
        h.seq_num = s.their_ack_num + $urandom_range(1, 3000);
      else h.seq_num = $urandom;
      h.ack_flag = ($urandom % 4) != 0;
      if ($urandom % 5 == 0) h.ack_num = s.our_ack_state.ack_num;
      else h.ack_num = s.our_ack_state.ack_num + $urandom_range(0, 6000);
      h.window = 16'($urandom);
      p.addr = $urandom;
      if ($urandom % 6 == 0) p.size = 0;
      else p.size = 16'($urandom_range(1, 2000));
      start_seg(f, h, p);
      finish_seg();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tcp_rx_proto_calc.md
Name: tcp_rx_proto_calc

Overview:
- Receive-side protocol calculation for the slow-path TCP engine; mirror of the transmit proto-calc stage.
- Takes one parsed inbound TCP header (plus flowid and payload descriptor) per transaction from the RX parser.
- Reads per-flow RX and TX state, then checks in-order sequence and ACK validity.
- Writes back updated RX state, frees acknowledged TX buffer space, commits or drops the payload, and sends one update command to the scheduler (ack-pending SET, retransmit-pending CLEAR).

Parameters:
- FLOWID_W, 8, flow id width; also the depth exponent of the state tables.
- RX_PAYLOAD_PTR_W, 14, RX payload buffer pointer width. The commit address is taken modulo 2^RX_PAYLOAD_PTR_W.
- TX_PAYLOAD_PTR_W, 14, TX payload buffer pointer width. Used for the head-pointer update.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_hdr_val  in  1  inbound segment valid
- rx_hdr_rdy  out  1  inbound segment ready
- rx_hdr  in  tcp_pkt_hdr  parsed TCP header
- rx_flowid  in  FLOWID_W  flow of the segment
- rx_payload  in  payload_buf_struct  payload location and length in the staging buffer
- rx_state_rd_req_addr  out  FLOWID_W  RX state read address; 1-cycle read latency
- rx_state_rd_resp_data  in  smol_rx_state_struct  RX state read data
- tx_state_rd_req_addr  out  FLOWID_W  TX state read address; 1-cycle read latency
- tx_state_rd_resp_data  in  smol_tx_state_struct  TX state read data
- rx_state_wr_req_val  out  1  RX state write strobe
- rx_state_wr_req_addr  out  FLOWID_W  RX state write address
- rx_state_wr_req_data  out  smol_rx_state_struct  RX state write data
- tx_head_ptr_wr_req_val  out  1  TX buffer head-pointer update strobe
- tx_head_ptr_wr_req_addr  out  FLOWID_W  head-pointer flow
- tx_head_ptr_wr_req_data  out  TX_PAYLOAD_PTR_W+1  new head pointer, i.e. acked ptr
- rx_commit_val  out  1  payload commit/drop valid
- rx_commit_rdy  in  1  payload commit/drop ready
- rx_commit_accept  out  1  1 = copy payload to the flow RX buffer; 0 = free the staging slot
- rx_commit_desc  out  payload_buf_struct  destination address and length
- rx_commit_flowid  out  FLOWID_W  flow of the commit
- rx_sched_update_val  out  1  scheduler update valid
- rx_sched_update_rdy  in  1  scheduler update ready
- rx_sched_update_cmd  out  sched_cmd_struct  flag set/clear command

Behaviour:
- FSM states: IDLE, RD_STATE, CALC, OUTPUT.
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - All val outputs go to 0; rx_hdr_rdy goes to 0 during reset and to 1 in IDLE.
  - Data registers are cleared to '0.
  - Any in-flight segment is discarded and no partial write is issued.
- IDLE: rdy=1. When val and rdy are both high, latch header, flowid and payload, then go to RD_STATE.
- RD_STATE: drive read addresses from the latched flowid. Next cycle, latch both state responses and go to CALC.
- CALC (1 cycle), all arithmetic mod 2^32:
  - in_order = (hdr.seq_num == their_ack_num).
  - fits = payload_len <= our_win_size.
  - accept = in_order & fits & (payload_len != 0).
  - If accept:
    - their_ack_num_new = their_ack_num + payload_len.
    - our_win_size_new = our_win_size - payload_len.
    - Commit address = their_ack_num[RX_PAYLOAD_PTR_W-1:0].
  - If not accept: their_ack_num and our_win_size are unchanged, and rx_commit_accept=0.
  - ACK check: applies only when the ACK flag is set. Let d_ack = hdr.ack_num - our_ack_state.ack_num and d_out = our_seq_num - our_ack_state.ack_num.
    - new_ack = (d_ack != 0) & (d_ack <= d_out).
    - If new_ack, our_ack_state.ack_num = hdr.ack_num.
    - their_win_size = hdr.window when d_ack <= d_out (covers equal and new ACKs).
    - Otherwise the ACK is stale or beyond what we sent: ignore ack_num and window.
  - Scheduler command (others NOP, flowid set, timestamps '0):
    - ack_pend SET if payload_len != 0, so out-of-order segments generate a duplicate ACK.
    - rt_pend CLEAR if new_ack.
    - data_pend SET if new_ack (window may have opened).
- OUTPUT:
  - rx_state_wr_req_val and tx_head_ptr_wr_req_val (the latter only if new_ack) pulse for exactly 1 cycle, on the first OUTPUT cycle.
  - tx_head_ptr_wr_req_data = hdr.ack_num[TX_PAYLOAD_PTR_W:0].
  - rx_commit_val is raised unless payload_len == 0.
  - rx_sched_update_val is raised if any command is non-NOP.
  - Each val is held until its own rdy; the handshakes may complete in any order or cycle.
  - Go to IDLE when all raised vals have completed.
- Throughput: one segment per at least 4 cycles. The state write always precedes the next read, so back-to-back same-flow segments see fresh state without a forwarding path.
- Wrap-around: sequence and ACK compares are modular. A buffer address wrap is expected and handled by the copy engine.

Decomposition:
- tcp_pkg owns the shared types: tcp_pkt_hdr, smol_rx_state_struct, smol_tx_state_struct, sched_cmd_struct with its SET/CLEAR/NOP encoding, and payload_buf_struct.
- New rx_fsm_state_e enum goes in tcp_misc_pkg.
- One natural sub-module: tcp_ack_window_check, combinational, producing d_ack, new_ack and win_valid, so it can be unit-tested for wrap.

Test Plan:
- In-order data: their_ack=1000, seq=1000, len=200, win=4096 -> commit accept=1 addr=1000 len=200; state their_ack=1200, our_win=3896; sched ack_pend SET.
- Out-of-order: their_ack=1000, seq=1400, len=100 -> accept=0; state unchanged; ack_pend SET.
- New ACK with seq wrap: ack_state=0xFFFFFFF0, our_seq=0x00000010, hdr.ack=0x00000008, window=512 -> new_ack; head ptr=0x0008; rt_pend CLEAR; their_win=512.
- Stale/invalid ACK: ack_state=500, our_seq=600, hdr.ack=700 -> ack and window ignored; no head-pointer write; no sched update for a pure ACK.
- Backpressure: hold rx_sched_update_rdy=0 for 10 cycles while commit completes -> rx_hdr_rdy stays 0, the state write is not repeated, and the FSM returns to IDLE 1 cycle after rdy.
- Reset asserted in OUTPUT -> all vals 0 immediately; after release rdy=1 and the next segment is processed correctly.
